bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3, "double dabble") that sits directly downstream of the multiplier core in the calculator datapath. It takes the 16-bit product and its one-cycle completion pulse, and converts the product into five packed BCD digits over WIDTH clock cycles. The digits feed the display/readback path and are held stable until the next conversion completes.

---
 rtl/calc_pkg.sv | 15 +
 rtl/bin2bcd_seq_if.sv | 19 +
 rtl/bin2bcd_seq_add3.sv | 8 +
 rtl/bin2bcd_seq.sv | 92 +++++++++
 tb/tb_bin2bcd_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: converter state encoding, BCD digit
// width, and the default product/display sizes.
package calc_pkg;

  localparam int BCD_W      = 4;
  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between the multiplier (master) and the BCD converter (slave).
//
// Handshake: start is a one-cycle request carrying bin. There is no ready signal.
// The request is taken only when the converter is not busy, and it is silently
// dropped while busy=1. done is a one-cycle pulse marking the cycle in which bcd
// first holds the new result. bcd then stays stable until the next done.
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) ();
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit corrector: a digit of 5 or more gets +3, so that the
// following left shift carries into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter. It runs one shift per cycle
// for WIDTH cycles, and the result register is updated only on completion.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic             clk,
  input  logic             reset,
  bin2bcd_seq_if.slave     bus,
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int SCR_W = BCD_W * DIGITS;

  state_t              state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [WIDTH-1:0]    sr_q, sr_n;
  logic [SCR_W-1:0]    scr_q, scr_n;
  logic [SCR_W-1:0]    bcd_q, bcd_n;
  logic                busy_q, done_q;
  logic [SCR_W-1:0]    scr_adj;
  logic [SCR_W+WIDTH-1:0] shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scr_q[g*BCD_W +: BCD_W]),
      .dout (scr_adj[g*BCD_W +: BCD_W])
    );
  end

  // The top scratch bit is shifted out. It never holds data when 10^DIGITS > 2^WIDTH-1.
  assign shifted = {scr_adj, sr_q} << 1;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    sr_n    = sr_q;
    scr_n   = scr_q;
    bcd_n   = bcd_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n = ST_SHIFT;
          sr_n    = bus.bin;
          scr_n   = '0;
          cnt_n   = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        scr_n = shifted[SCR_W+WIDTH-1:WIDTH];
        sr_n  = shifted[WIDTH-1:0];
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_n = ST_DONE;
          bcd_n   = shifted[SCR_W+WIDTH-1:WIDTH];
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      scr_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      sr_q    <= sr_n;
      scr_q   <= scr_n;
      bcd_q   <= bcd_n;
      busy_q  <= (state_n == ST_SHIFT);
      done_q  <= (state_n == ST_DONE);
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed corner cases plus random conversions, checked
// against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;
  import calc_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];
  logic [19:0] last_bcd = '0;

  bin2bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] model(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: call at a negedge; the request is sampled on the next posedge
  task automatic launch(input logic [15:0] v);
    bus.start = 1'b1;
    bus.bin   = v;
    exp_q.push_back(model(int'(v)));
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 16'($urandom);
  endtask

  // Called one negedge after the start edge. It returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input int ovr_at, input logic [15:0] ovr_v);
    int cyc = 1;
    int busy_cnt = 0;
    int hold_err = 0;
    logic [19:0] e;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.bcd !== last_bcd) hold_err++;
      if (cyc == ovr_at) begin
        bus.start = 1'b1;
        bus.bin   = ovr_v;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h0;
    chk($sformatf("%s latency", tag), cyc, 17);
    chk($sformatf("%s busy_cycles", tag), busy_cnt, 16);
    chk($sformatf("%s hold_while_busy", tag), hold_err, 0);
    chk($sformatf("%s busy_at_done", tag), {31'b0, bus.busy}, 0);
    chk($sformatf("%s bcd", tag), {12'b0, bus.bcd}, {12'b0, e});
    last_bcd = e;
  endtask

  // idle cycles: no done pulse and no bcd change are allowed
  task automatic idle_check(input string tag, input int n);
    int done_cnt = 0;
    int chg = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.bcd !== last_bcd) chg++;
    end
    chk($sformatf("%s no_done", tag), done_cnt, 0);
    chk($sformatf("%s bcd_stable", tag), chg, 0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.bin   = '0;
    reset     = 1'b1;
    #3 reset  = 1'b0;
    #1;
    chk("reset busy", {31'b0, bus.busy}, 0);
    chk("reset done", {31'b0, bus.done}, 0);
    chk("reset bcd", {12'b0, bus.bcd}, 0);
    chk("reset state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    launch(16'd0);     wait_done("zero", 0, 0);   idle_check("zero", 2);
    launch(16'd65535); wait_done("max", 0, 0);    idle_check("max", 2);
    launch(16'd65025); wait_done("sq255", 0, 0);  idle_check("sq255", 2);
    launch(16'd1234);  wait_done("1234", 0, 0);   idle_check("1234", 2);

    // overrun: a second start during SHIFT must be dropped
    launch(16'd4321);  wait_done("overrun", 5, 16'd777);
    idle_check("overrun", 25);

    // back-to-back: second start issued in the DONE cycle
    launch(16'd31415); wait_done("b2b_a", 0, 0);
    launch(16'd9);     wait_done("b2b_b", 0, 0);
    idle_check("b2b", 2);

    // reset in mid-conversion
    launch(16'd50000);
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("midrst busy", {31'b0, bus.busy}, 0);
    chk("midrst done", {31'b0, bus.done}, 0);
    chk("midrst bcd", {12'b0, bus.bcd}, 0);
    chk("midrst state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.delete();
    last_bcd = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle_check("midrst", 30);
    @(negedge clk);
    launch(16'd4095);  wait_done("after_rst", 0, 0);

    // hold: bin toggles without start
    begin
      int bad = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        bus.bin = 16'($urandom);
        if (bus.bcd !== last_bcd || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
      end
      chk("hold", bad, 0);
    end

    // random conversions, with a mix of idle gaps and back-to-back starts
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      launch(16'($urandom_range(0, 65535)));
      wait_done($sformatf("rand%0d", i), 0, 0);
      if ($urandom_range(0, 1) == 1) idle_check($sformatf("rand%0d", i), $urandom_range(1, 3));
    end
    idle_check("final", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
